// File: rtl/picosoc_timer_pkg.sv
// rtl/picosoc_timer_pkg.sv - register map, CTRL layout and shared helpers for the iomem timer
package picosoc_timer_pkg;

   localparam logic [2:0] TMR_CTRL     = 3'd0;
   localparam logic [2:0] TMR_PRESCALE = 3'd1;
   localparam logic [2:0] TMR_RELOAD   = 3'd2;
   localparam logic [2:0] TMR_COUNT    = 3'd3;
   localparam logic [2:0] TMR_STATUS   = 3'd4;
   localparam logic [2:0] TMR_CYC_LO   = 3'd5;
   localparam logic [2:0] TMR_CYC_HI   = 3'd6;
   localparam logic [2:0] TMR_CLKHZ    = 3'd7;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } ctrl_t;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_t;

   // Byte-lane merge of a bus write into the current register contents.
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wr,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wr[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/picosoc_timer_prescaler.sv
// rtl/picosoc_timer_prescaler.sv - divides clk into one tick every div+1 cycles while enabled
module picosoc_timer_prescaler (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [15:0] div,
   input  logic        restart,
   output logic        tick
);

   logic [15:0] pcnt;

   assign tick = en && (pcnt == div);

   always_ff @(posedge clk) begin
      if (reset || !en || restart) begin
         pcnt <= 16'd0;
      end else if (tick) begin
         pcnt <= 16'd0;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

endmodule

// File: rtl/picosoc_timer.sv
// rtl/picosoc_timer.sv - iomem countdown timer with 64-bit cycle counter and level irq
module picosoc_timer
   import picosoc_timer_pkg::*;
#(
   parameter int CLOCK_SPEED_HZ = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        iomem_ready,
   output logic        irq_o
);

   bus_state_t  state, state_next;
   ctrl_t       ctrl, ctrl_next;
   logic [15:0] prescale;
   logic [31:0] reload;
   logic [31:0] count;
   logic        expired;
   logic [63:0] cycle_cnt;
   logic [31:0] hi_latch;
   logic [31:0] read_mux;

   logic [2:0]  sel;
   logic        wr_commit, rd_start;
   logic        wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
   logic        tick, tick_eff, expire;
   logic [31:0] ctrl_merged, prescale_merged, reload_merged, count_merged;
   logic        unused_bits;

   assign sel         = iomem_addr[4:2];
   assign iomem_ready = (state == BUS_ACK);
   assign irq_o       = expired && ctrl.irq_en;

   // Writes land at the end of the ACK cycle; reads are captured entering ACK.
   assign wr_commit   = (state == BUS_ACK) && iomem_valid && (iomem_wstrb != 4'd0);
   assign rd_start    = (state == BUS_IDLE) && iomem_valid && (iomem_wstrb == 4'd0);
   assign wr_ctrl     = wr_commit && (sel == TMR_CTRL);
   assign wr_prescale = wr_commit && (sel == TMR_PRESCALE);
   assign wr_reload   = wr_commit && (sel == TMR_RELOAD);
   assign wr_count    = wr_commit && (sel == TMR_COUNT);
   assign wr_status   = wr_commit && (sel == TMR_STATUS);

   assign unused_bits = ^{iomem_addr[31:5], iomem_addr[1:0],
                          ctrl_merged[31:3], prescale_merged[31:16]};

   always_ff @(posedge clk) begin
      if (reset) state <= BUS_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         BUS_IDLE: if (iomem_valid) state_next = BUS_ACK;
         BUS_ACK:  state_next = BUS_IDLE;
         default:  state_next = BUS_IDLE;
      endcase
   end

   picosoc_timer_prescaler u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .en      (ctrl.en),
      .div     (prescale),
      .restart (wr_count),
      .tick    (tick)
   );

   // A COUNT write in the same cycle swallows the tick.
   assign tick_eff = tick && !wr_count;
   assign expire   = tick_eff && (count == 32'd0);

   always_comb begin
      ctrl_merged     = merge_bytes({29'd0, ctrl}, iomem_wdata, iomem_wstrb);
      prescale_merged = merge_bytes({16'd0, prescale}, iomem_wdata, iomem_wstrb);
      reload_merged   = merge_bytes(reload, iomem_wdata, iomem_wstrb);
      count_merged    = merge_bytes(count, iomem_wdata, iomem_wstrb);
      ctrl_next       = ctrl;
      if (expire && !ctrl.auto_reload) ctrl_next.en = 1'b0;
      if (wr_ctrl) ctrl_next = ctrl_t'(ctrl_merged[2:0]);
   end

   always_comb begin
      read_mux = 32'd0;
      case (sel)
         TMR_CTRL:     read_mux = {29'd0, ctrl};
         TMR_PRESCALE: read_mux = {16'd0, prescale};
         TMR_RELOAD:   read_mux = reload;
         TMR_COUNT:    read_mux = count;
         TMR_STATUS:   read_mux = {31'd0, expired};
         TMR_CYC_LO:   read_mux = cycle_cnt[31:0];
         TMR_CYC_HI:   read_mux = hi_latch;
         TMR_CLKHZ:    read_mux = 32'(CLOCK_SPEED_HZ);
         default:      read_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl        <= '0;
         prescale    <= 16'd0;
         reload      <= 32'd0;
         count       <= 32'd0;
         expired     <= 1'b0;
         cycle_cnt   <= 64'd0;
         hi_latch    <= 32'd0;
         iomem_rdata <= 32'd0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         ctrl      <= ctrl_next;
         if (wr_prescale) prescale <= prescale_merged[15:0];
         if (wr_reload)   reload   <= reload_merged;

         if (wr_count) begin
            count <= count_merged;
         end else if (tick_eff) begin
            if (count != 32'd0)        count <= count - 32'd1;
            else if (ctrl.auto_reload) count <= reload;
         end

         // Expiry beats a simultaneous W1C so no event is lost.
         if (expire) begin
            expired <= 1'b1;
         end else if (wr_status && iomem_wstrb[0] && iomem_wdata[0]) begin
            expired <= 1'b0;
         end

         if (rd_start) begin
            iomem_rdata <= read_mux;
            if (sel == TMR_CYC_LO) hi_latch <= cycle_cnt[63:32];
         end else begin
            iomem_rdata <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_picosoc_timer.sv
// tb/tb_picosoc_timer.sv - self-checking bench for picosoc_timer against a behavioural model
module tb_picosoc_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        iomem_valid;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        iomem_ready;
   logic        irq_o;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   longint unsigned edges = 0;
   longint unsigned since_reset = 0;
   longint unsigned cyc_exp = 0;

   picosoc_timer dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .iomem_ready (iomem_ready),
      .irq_o       (irq_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      edges <= edges + 1;
      if (reset) since_reset <= 0;
      else       since_reset <= since_reset + 1;
   end

   // One bus transfer; start > 0 delays the request until that many edges have elapsed.
   task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input longint unsigned start, output logic [31:0] r);
      bit ok;
      ok = 0;
      r  = 32'hx;
      @(negedge clk);
      while (start != 0 && edges < start) @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = d;
      iomem_wstrb = s;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (iomem_ready) begin
            ok      = 1;
            r       = iomem_rdata;
            cyc_exp = since_reset - 1;
            break;
         end
      end
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bus_timeout addr=%h: ready never seen, required within 8 cycles", a);
      end
      @(posedge clk);
      #1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      bus_xfer(a, d, s, 0, dummy);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
      bus_xfer(a, 32'd0, 4'd0, 0, r);
   endtask

   task automatic wait_irq(input int budget, output longint unsigned at);
      at = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (irq_o) begin
            at = edges;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      iomem_addr  = 32'd0;
      iomem_wdata = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      logic [31:0] offs [6];
      offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18};
      do_reset();
      n_cmp++;
      if (iomem_ready !== 1'b0 || irq_o !== 1'b0 || iomem_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b irq=%b rdata=%h, required 0/0/0",
                  iomem_ready, irq_o, iomem_rdata);
      end
      foreach (offs[i]) begin
         bus_read(offs[i], r);
         n_cmp++;
         if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_read off=%h: got %h, required 0", offs[i], r);
         end
      end
      bus_read(32'h1C, r);
      n_cmp++;
      if (r !== 32'd50_000_000) begin
         n_fail++;
         $display("FAIL reset_clkhz: got %0d, required 50000000", r);
      end
      bus_read(32'h14, r);
      n_cmp++;
      if (r !== cyc_exp[31:0]) begin
         n_fail++;
         $display("FAIL reset_cyc_lo: got %0d, required %0d", r, cyc_exp[31:0]);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] r;
      bus_write(32'h04, 32'd0, 4'hF);
      bus_write(32'h0C, 32'd3, 4'hF);
      bus_write(32'h00, 32'b101, 4'hF);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (irq_o !== (k == 4)) begin
            n_fail++;
            $display("FAIL oneshot_irq cycle %0d: got %b, required %b", k, irq_o, (k == 4));
         end
      end
      bus_read(32'h00, r);
      n_cmp++;
      if (r !== 32'b100) begin
         n_fail++;
         $display("FAIL oneshot_ctrl: got %h, required 4 (en self-cleared)", r);
      end
      bus_read(32'h0C, r);
      n_cmp++;
      if (r !== 32'd0) begin
         n_fail++;
         $display("FAIL oneshot_count: got %h, required 0", r);
      end
      bus_write(32'h10, 32'd1, 4'hF);
      n_cmp++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_w1c: irq=%b, required 0", irq_o);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] dummy;
      longint unsigned c0, at;
      bus_write(32'h04, 32'd4, 4'hF);
      bus_write(32'h08, 32'd9, 4'hF);
      bus_write(32'h0C, 32'd9, 4'hF);
      bus_write(32'h00, 32'b111, 4'hF);
      c0 = edges;
      for (int p = 1; p <= 2; p++) begin
         wait_irq(120, at);
         n_cmp++;
         if (at !== c0 + 50 * p) begin
            n_fail++;
            $display("FAIL autoreload_period %0d: irq at edge %0d, required %0d", p, at, c0 + 50 * p);
         end
         bus_write(32'h10, 32'd1, 4'hF);
      end
      bus_xfer(32'h10, 32'd1, 4'hF, c0 + 148, dummy);
      n_cmp++;
      if (irq_o !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_vs_expiry: irq=%b at edge %0d, required 1", irq_o, edges);
      end
      bus_write(32'h00, 32'd0, 4'hF);
      bus_write(32'h10, 32'd1, 4'hF);
      n_cmp++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL autoreload_clear: irq=%b, required 0", irq_o);
      end
   endtask

   task automatic test_byte_write();
      logic [31:0] r;
      bus_write(32'h08, 32'h1122_3344, 4'hF);
      bus_write(32'h08, 32'h0000_AB00, 4'b0010);
      bus_read(32'h08, r);
      n_cmp++;
      if (r !== 32'h1122_AB44) begin
         n_fail++;
         $display("FAIL byte_write: got %h, required 1122ab44", r);
      end
   endtask

   task automatic test_random_regs();
      logic [31:0] model [3];
      logic [31:0] mask [3];
      logic [2:0]  offs [3];
      logic [31:0] r, d, a, want;
      logic [3:0]  s;
      int          k;
      bus_write(32'h00, 32'd0, 4'hF);
      bus_write(32'h04, 32'd0, 4'hF);
      bus_write(32'h08, 32'd0, 4'hF);
      model = '{32'd0, 32'd0, 32'd0};
      mask  = '{32'h6, 32'hFFFF, 32'hFFFF_FFFF};
      offs  = '{3'd0, 3'd1, 3'd2};
      for (int it = 0; it < 20; it++) begin
         k = $urandom_range(0, 2);
         d = $urandom;
         if (k == 0) d[0] = 1'b0;
         s = 4'($urandom_range(1, 15));
         a = ($urandom & 32'hFFFF_FFE0) | {27'd0, offs[k], 2'b00} | ($urandom & 32'h3);
         bus_write(a, d, s);
         for (int b = 0; b < 4; b++)
            if (s[b]) model[k] = (model[k] & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
         model[k] = model[k] & mask[k];
         bus_read({27'd0, offs[k], 2'b00}, r);
         want = model[k];
         n_cmp++;
         if (r !== want) begin
            n_fail++;
            $display("FAIL rand_reg it=%0d off=%0d strb=%b: got %h, required %h", it, k, s, r, want);
         end
      end
      bus_write(32'h00, 32'd0, 4'hF);
   endtask

   task automatic test_random_oneshot();
      logic [31:0] r;
      longint unsigned c0, at;
      int p, c;
      for (int it = 0; it < 6; it++) begin
         p = $urandom_range(0, 3);
         c = $urandom_range(0, 6);
         bus_write(32'h04, 32'(p), 4'hF);
         bus_write(32'h0C, 32'(c), 4'hF);
         bus_write(32'h00, 32'b101, 4'hF);
         c0 = edges;
         wait_irq(100, at);
         n_cmp++;
         if (at !== c0 + longint'((c + 1) * (p + 1))) begin
            n_fail++;
            $display("FAIL rand_oneshot p=%0d c=%0d: expiry %0d cycles after enable, required %0d",
                     p, c, (at == 0) ? -1 : longint'(at - c0), (c + 1) * (p + 1));
         end
         bus_read(32'h00, r);
         n_cmp++;
         if (r !== 32'b100) begin
            n_fail++;
            $display("FAIL rand_oneshot_ctrl p=%0d c=%0d: got %h, required 4", p, c, r);
         end
         bus_write(32'h10, 32'd1, 4'hF);
      end
      bus_write(32'h04, 32'd0, 4'hF);
   endtask

   task automatic test_cycle_snapshot();
      logic [31:0] lo, hi;
      @(negedge clk);
      force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFC;
      @(negedge clk);
      release dut.cycle_cnt;
      bus_read(32'h14, lo);
      bus_read(32'h18, hi);
      n_cmp++;
      if (lo[31:8] !== 24'hFF_FFFF) begin
         n_fail++;
         $display("FAIL cyc_lo_pre_wrap: got %h, required ffffffxx", lo);
      end
      n_cmp++;
      if (hi !== 32'd1) begin
         n_fail++;
         $display("FAIL cyc_hi_snapshot: got %h, required 1", hi);
      end
      bus_read(32'h14, lo);
      bus_read(32'h18, hi);
      n_cmp++;
      if (hi !== 32'd2 || lo >= 32'h100) begin
         n_fail++;
         $display("FAIL cyc_carry: got hi=%h lo=%h, required hi=2 lo<100", hi, lo);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] r;
      bit seen;
      seen = 0;
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h08;
      iomem_wdata = 32'hDEAD_BEEF;
      iomem_wstrb = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (iomem_ready) begin
            seen = 1;
            break;
         end
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (!seen || iomem_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_ready: seen=%0d ready=%b, required seen=1 ready=0", seen, iomem_ready);
      end
      @(negedge clk);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      reset       = 1'b0;
      bus_read(32'h08, r);
      n_cmp++;
      if (r !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_reload: got %h, required 0", r);
      end
      bus_write(32'h04, 32'd0, 4'hF);
      bus_write(32'h0C, 32'd1000, 4'hF);
      bus_write(32'h00, 32'b001, 4'hF);
      bus_write(32'h0C, 32'h55, 4'hF);
      bus_read(32'h0C, r);
      n_cmp++;
      if (r !== 32'h55) begin
         n_fail++;
         $display("FAIL count_write_vs_tick: got %h, required 55", r);
      end
      bus_write(32'h00, 32'd0, 4'hF);
   endtask

   initial begin
      reset       = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      iomem_addr  = 32'd0;
      iomem_wdata = 32'd0;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_byte_write();
      test_random_regs();
      test_random_oneshot();
      test_cycle_snapshot();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
